// File: rtl/round_robin_weighted_arbiter.sv
// Four-requester round-robin arbiter with per-requester burst credit.
// The owner keeps the grant for up to its weight in cycles, then priority rotates past it.
module round_robin_weighted_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  request,
  input  logic [11:0] weight,
  output logic [3:0]  grant,
  output logic        grant_valid,
  output logic [1:0]  grant_id
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0] state;
  logic [2:0] cnt;
  logic [1:0] last;

  logic       release_now;
  logic [1:0] ptr;
  logic [1:0] winner;
  logic [2:0] win_weight;
  logic [2:0] win_credit;
  logic [2:0] w_arr [4];

  // First requester found after ptr (ptr itself checked last); ptr if nobody requests.
  function automatic logic [1:0] pick(input logic [3:0] req, input logic [1:0] p);
    logic [1:0] idx;
    pick = p;
    for (int k = 4; k >= 1; k--) begin
      idx = p + 2'(k);
      if (req[idx]) pick = idx;
    end
  endfunction

  // NOTE: every signal gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    for (int i = 0; i < 4; i++) w_arr[i] = weight[3*i +: 3];
    release_now = !request[grant_id] || (cnt == 3'd1);
    // A releasing owner becomes the new pointer in the same edge.
    ptr         = (state == BUSY) ? grant_id : last;
    winner      = pick(request, ptr);
    win_weight  = w_arr[winner];
    win_credit  = (win_weight == 3'd0) ? 3'd1 : win_weight;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      last        <= 2'd3;
      grant       <= 4'b0000;
      grant_valid <= 1'b0;
      grant_id    <= 2'd0;
    end else if (state == IDLE) begin
      if (|request) begin
        state       <= BUSY;
        cnt         <= win_credit;
        grant       <= 4'b0001 << winner;
        grant_valid <= 1'b1;
        grant_id    <= winner;
      end
    end else begin
      if (!release_now) begin
        cnt <= cnt - 3'd1;
      end else begin
        last <= grant_id;
        if (|request) begin
          cnt         <= win_credit;
          grant       <= 4'b0001 << winner;
          grant_valid <= 1'b1;
          grant_id    <= winner;
        end else begin
          state       <= IDLE;
          cnt         <= 3'd0;
          grant       <= 4'b0000;
          grant_valid <= 1'b0;
          grant_id    <= 2'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_round_robin_weighted_arbiter.sv
// Bench for round_robin_weighted_arbiter: directed cycle-by-cycle vector table,
// then randomized traffic against a cycle-level behavioural model.
module tb_round_robin_weighted_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  request;
  logic [11:0] weight;
  logic [3:0]  grant;
  logic        grant_valid;
  logic [1:0]  grant_id;

  int checks = 0;
  int failures = 0;

  round_robin_weighted_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .request     (request),
    .weight      (weight),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_v;
    logic [3:0]  req;
    logic [11:0] wt;
    logic [3:0]  exp_grant;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] pack_w(input int w0, input int w1, input int w2, input int w3);
    return {3'(w3), 3'(w2), 3'(w1), 3'(w0)};
  endfunction

  task automatic add(input logic r, input logic [3:0] q, input logic [11:0] w, input logic [3:0] g);
    vec_t v;
    v.rst_v = r; v.req = q; v.wt = w; v.exp_grant = g;
    vecs.push_back(v);
  endtask

  task automatic add_n(input int n, input logic r, input logic [3:0] q, input logic [11:0] w,
                       input logic [3:0] g);
    for (int i = 0; i < n; i++) add(r, q, w, g);
  endtask

  function automatic logic [1:0] onehot_idx(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return 2'(i);
    return 2'd0;
  endfunction

  // Behavioural model: owner index (-1 = none), cycles of credit left, last owner.
  int m_owner = -1;
  int m_left  = 0;
  int m_last  = 3;

  function automatic void model_step(input logic r, input logic [3:0] q, input logic [11:0] w);
    int budget;
    if (!r) begin
      m_owner = -1; m_left = 0; m_last = 3;
      return;
    end
    if (m_owner >= 0 && q[m_owner] && m_left > 1) begin
      m_left--;
      return;
    end
    if (m_owner >= 0) m_last = m_owner;
    m_owner = -1;
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (m_last + k) % 4;
      if (m_owner < 0 && q[idx]) begin
        m_owner = idx;
        budget  = int'(w[3*idx +: 3]);
        m_left  = (budget == 0) ? 1 : budget;
      end
    end
  endfunction

  initial begin
    logic [11:0] w1234, w2222;
    logic [3:0]  eg;
    w1234 = pack_w(1, 2, 3, 4);
    w2222 = pack_w(2, 2, 2, 2);

    // Reset priority, then weighted rotation 1/2/3/4 with no gaps.
    add_n(2, 1'b0, 4'b1111, w1234, 4'b0000);
    add_n(1, 1'b1, 4'b1111, w1234, 4'b0001);
    add_n(2, 1'b1, 4'b1111, w1234, 4'b0010);
    add_n(3, 1'b1, 4'b1111, w1234, 4'b0100);
    add_n(4, 1'b1, 4'b1111, w1234, 4'b1000);
    add_n(1, 1'b1, 4'b1111, w1234, 4'b0001);
    add_n(1, 1'b1, 4'b1111, w1234, 4'b0010);
    // Mid-grant reset: owner 3 holding credit 3, then requester 0 first after release.
    add  (1'b0, 4'b1111, w1234, 4'b0000);
    add  (1'b1, 4'b1000, pack_w(1, 2, 3, 3), 4'b1000);
    add  (1'b0, 4'b1111, w1234, 4'b0000);
    add  (1'b1, 4'b1111, w1234, 4'b0001);
    add  (1'b1, 4'b1111, w1234, 4'b0010);
    // Alternation between requesters 1 and 3.
    add  (1'b0, 4'b0000, w2222, 4'b0000);
    add_n(2, 1'b1, 4'b1010, w2222, 4'b0010);
    add_n(2, 1'b1, 4'b1010, w2222, 4'b1000);
    add_n(2, 1'b1, 4'b1010, w2222, 4'b0010);
    // Early release back to idle, idle holds.
    add  (1'b0, 4'b0000, pack_w(0, 0, 5, 0), 4'b0000);
    add_n(2, 1'b1, 4'b0100, pack_w(0, 0, 5, 0), 4'b0100);
    add_n(2, 1'b1, 4'b0000, pack_w(0, 0, 5, 0), 4'b0000);
    // Sole requester: continuous re-grant, weight 0 acts as 1.
    add  (1'b0, 4'b0000, pack_w(3, 0, 0, 0), 4'b0000);
    add_n(7, 1'b1, 4'b0001, pack_w(3, 0, 0, 0), 4'b0001);
    add_n(3, 1'b1, 4'b0001, pack_w(0, 0, 0, 0), 4'b0001);
    // Exhausted owner yields when another requester is active.
    add  (1'b0, 4'b0000, pack_w(2, 1, 0, 0), 4'b0000);
    add_n(2, 1'b1, 4'b0011, pack_w(2, 1, 0, 0), 4'b0001);
    add  (1'b1, 4'b0011, pack_w(2, 1, 0, 0), 4'b0010);
    add_n(2, 1'b1, 4'b0011, pack_w(2, 1, 0, 0), 4'b0001);
    add  (1'b1, 4'b0011, pack_w(2, 1, 0, 0), 4'b0010);
    // Weight change while busy leaves the running credit alone.
    add  (1'b0, 4'b0000, pack_w(3, 1, 0, 0), 4'b0000);
    add  (1'b1, 4'b0001, pack_w(3, 1, 0, 0), 4'b0001);
    add_n(2, 1'b1, 4'b0011, pack_w(7, 1, 0, 0), 4'b0001);
    add  (1'b1, 4'b0011, pack_w(7, 1, 0, 0), 4'b0010);
    add  (1'b1, 4'b0011, pack_w(7, 1, 0, 0), 4'b0001);
    // Non-owner requests come and go without disturbing the owner.
    add  (1'b0, 4'b0000, pack_w(4, 1, 1, 0), 4'b0000);
    add  (1'b1, 4'b0111, pack_w(4, 1, 1, 0), 4'b0001);
    add  (1'b1, 4'b0001, pack_w(4, 1, 1, 0), 4'b0001);
    add  (1'b1, 4'b0101, pack_w(4, 1, 1, 0), 4'b0001);
    add  (1'b1, 4'b0001, pack_w(4, 1, 1, 0), 4'b0001);
    add  (1'b1, 4'b0110, pack_w(4, 1, 1, 0), 4'b0010);

    rst = 1'b0; request = 4'b0000; weight = 12'd0;
    @(posedge clk); #1;
    check("reset_grant", 32'(grant), 32'(4'b0000));
    check("reset_valid", 32'(grant_valid), 32'(1'b0));
    check("reset_id", 32'(grant_id), 32'(2'd0));

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst_v; request = vecs[i].req; weight = vecs[i].wt;
      @(posedge clk); #1;
      check($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
      check($sformatf("vec%0d_valid", i), 32'(grant_valid), 32'(|vecs[i].exp_grant));
      check($sformatf("vec%0d_id", i), 32'(grant_id), 32'(onehot_idx(vecs[i].exp_grant)));
    end

    // Randomized traffic against the model, starting from reset.
    rst = 1'b0; request = 4'b0000;
    @(posedge clk); #1;
    model_step(rst, request, weight);
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 3) == 0) request = 4'($urandom);
      if ($urandom_range(0, 7) == 0) weight = 12'($urandom);
      @(posedge clk); #1;
      model_step(rst, request, weight);
      eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
      check($sformatf("rand%0d_grant", c), 32'(grant), 32'(eg));
      check($sformatf("rand%0d_valid", c), 32'(grant_valid), 32'(m_owner >= 0));
      check($sformatf("rand%0d_id", c), 32'(grant_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
